apb_arb_master: RTL and testbench

- Two-requester APB master that shares the APB bus between two local command ports.
- Arbitrates round-robin between the two ports and sequences the APB SETUP and ACCESS phases.
- Decodes the target from address bit 8 onto PSEL1 or PSEL2, waits for the selected slave's PREADY, and returns a tagged response.
- Sits between the system-side requesters and the 64-entry APB slave memories.

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/apb_arb_master.sv | 179 +++++++++++++++++
 tb/tb_apb_arb_master.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-port APB arbitrating master.
// Slave select is the top address bit; PADDR carries the low APB_ADDR_W bits.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int ADDR_W_DEF = 9;
  localparam int APB_ADDR_W = 8;
  localparam int ID_W       = 1;

  function automatic int slv_sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction

  localparam int SLV_SEL_BIT = slv_sel_bit(ADDR_W_DEF);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. The pointer names the preferred port and moves
// to the port that was not granted whenever a request is accepted.
module rr_arbiter2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  logic rr_ptr_q;
  logic ptr_valid;

  always_comb begin
    ptr_valid   = rr_ptr_q ? valid1_i : valid0_i;
    gnt_valid_o = enable_i && (valid0_i || valid1_i);
    gnt_id_o    = ptr_valid ? rr_ptr_q : ~rr_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= 1'b0;
    end else if (accept_i) begin
      rr_ptr_q <= ~gnt_id_o;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin accept, SETUP/ACCESS sequencing,
// PSEL1/PSEL2 decode on the top address bit. APB_TIMEOUT_EN adds an ACCESS wait limit.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // Handshake: a request transfers on the cycle where reqN_valid && reqN_ready;
  // the requester holds valid and payload until then, and ready is only ever
  // high for the single granted port while the master is idle.
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA1,
  input  logic [DATA_W-1:0]     PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  output apb_state_e            dbg_state_o
);

  localparam int SEL_BIT = slv_sel_bit(ADDR_W);

  apb_state_e            state_q;
  logic                  sel_q;
  logic [ID_W-1:0]       id_q;
  logic                  psel1_q, psel2_q, penable_q, pwrite_q;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_W-1:0]     rsp_rdata_q;

  logic                  gnt_valid, gnt_id, fire;
  logic                  g_write;
  logic [ADDR_W-1:0]     g_addr;
  logic [DATA_W-1:0]     g_wdata;
  logic                  pready_sel;
  logic [DATA_W-1:0]     prdata_sel;

  rr_arbiter2 u_arb (
    .clk_i       (PCLK),
    .rst_i       (PRESET),
    .enable_i    (state_q == IDLE),
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .accept_i    (fire),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid && gnt_id;
  assign fire       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    g_write    = gnt_id ? req1_write : req0_write;
    g_addr     = gnt_id ? req1_addr  : req0_addr;
    g_wdata    = gnt_id ? req1_wdata : req0_wdata;
    // Only the addressed slave's PREADY/PRDATA are meaningful.
    pready_sel = sel_q ? PREADY2 : PREADY1;
    prdata_sel = sel_q ? PRDATA2 : PRDATA1;
  end

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      id_q        <= '0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            sel_q     <= g_addr[SEL_BIT];
            id_q      <= ID_W'(gnt_id);
            psel1_q   <= !g_addr[SEL_BIT];
            psel2_q   <= g_addr[SEL_BIT];
            penable_q <= 1'b0;
            pwrite_q  <= g_write;
            paddr_q   <= g_addr[APB_ADDR_W-1:0];
            pwdata_q  <= g_wdata;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
        end
        ACCESS: begin
          // A ready on the last allowed cycle still completes normally.
          if (pready_sel) begin
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : prdata_sel;
            state_q     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSEL1       = psel1_q;
  assign PSEL2       = psel2_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master; expected responses are queued at accept
// and popped when rsp_valid appears. Honours APB_TIMEOUT_EN.
module tb_apb_arb_master;
  import apb_arb_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
`ifdef APB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 16;
`endif
  localparam int RW = 2 + DATA_W;

  logic              PCLK, PRESET;
  logic              req0_valid, req0_ready, req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp_valid, rsp_err;
  logic [0:0]        rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
  logic              PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0]        PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA1, PRDATA2;
  logic              PREADY1, PREADY2;
  apb_state_e        dbg_state;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp;
  int total = 0;
  int bad   = 0;

  apb_arb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // driver tasks
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic test_reset();
    PRESET = 1; idle_inputs();
    PRDATA1 = 8'h00; PRDATA2 = 8'h00; PREADY1 = 0; PREADY2 = 0;
    tick(); tick();
    total++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_id, rsp_rdata, rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_id, rsp_rdata, rsp_err});
    end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    PRESET = 0;
    // Both valid for a moment (dropped before any edge): port 0 preferred after reset.
    req0_valid = 1; req1_valid = 1;
    settle();
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_rr_ptr: ready={%b,%b} want {1,0}", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
    settle();
  endtask

  task automatic test_write_p0();
    PREADY1 = 1; PREADY2 = 0; PRDATA1 = 8'hFF;
    tick();
    req0_valid = 1; req0_write = 1; req0_addr = 9'h005; req0_wdata = 8'hA5;
    settle();
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL wr_ready: ready={%b,%b} want {1,0}", req0_ready, req1_ready);
    end
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    tick();
    idle_inputs();
    total++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'hA5}) begin
      bad++; $display("FAIL wr_setup: got %h want %h", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA},
                      {1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'hA5});
    end
    tick();
    total++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid} !== {1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'hA5, 1'b0}) begin
      bad++; $display("FAIL wr_access: got %h want %h", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid},
                      {1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'hA5, 1'b0});
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL wr_rsp: rsp_valid=%b queued=%0d want 1 and >0", rsp_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if ({rsp_id, rsp_err, rsp_rdata} !== exp) begin
        bad++; $display("FAIL wr_rsp: got %h want %h", {rsp_id, rsp_err, rsp_rdata}, exp);
      end
    end
    total++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin bad++; $display("FAIL wr_release: got %b want 000", {PSEL1, PSEL2, PENABLE}); end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read_wait_p1();
    PREADY1 = 1; PREADY2 = 0; PRDATA1 = 8'h11; PRDATA2 = 8'h3C;
    req1_valid = 1; req1_write = 0; req1_addr = 9'h105; req1_wdata = 8'h00;
    settle();
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL rd_ready: ready={%b,%b} want {0,1}", req0_ready, req1_ready);
    end
    exp_q.push_back({1'b1, 1'b0, 8'h3C});
    tick();
    idle_inputs();
    total++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h05}) begin
      bad++; $display("FAIL rd_setup: got %h want %h", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR},
                      {1'b0, 1'b1, 1'b0, 1'b0, 8'h05});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, rsp_valid} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0}) begin
        bad++; $display("FAIL rd_wait%0d: got %h want %h", k, {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, rsp_valid},
                        {1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0});
      end
      if (k == 3) PREADY2 = 1;
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL rd_rsp: rsp_valid=%b queued=%0d want 1 and >0", rsp_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if ({rsp_id, rsp_err, rsp_rdata} !== exp) begin
        bad++; $display("FAIL rd_rsp: got %h want %h", {rsp_id, rsp_err, rsp_rdata}, exp);
      end
    end
    total++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin bad++; $display("FAIL rd_release: got %b want 000", {PSEL1, PSEL2, PENABLE}); end
  endtask

  task automatic test_back_to_back();
    int   n_acc = 0;
    int   n_rsp = 0;
    int   last_acc = 0;
    int   acc_port;
    logic exp_gnt = 1'b0;
    PRESET = 1; tick(); PRESET = 0;
    PREADY1 = 1; PREADY2 = 1; PRDATA1 = 8'h00; PRDATA2 = 8'h5A;
    req0_valid = 1; req0_write = 1; req0_addr = 9'h000; req0_wdata = 8'($urandom_range(0, 255));
    req1_valid = 1; req1_write = 0; req1_addr = 9'h140; req1_wdata = 8'h00;
    for (int cyc = 0; cyc < 40; cyc++) begin
      settle();
      acc_port = -1;
      total++;
      if (req0_ready && req1_ready) begin bad++; $display("FAIL b2b_both_ready: cycle %0d got 11 want not 11", cyc); end
      if (req0_ready || req1_ready) begin
        acc_port = req1_ready ? 1 : 0;
        total++;
        if (req1_ready !== exp_gnt) begin bad++; $display("FAIL b2b_grant: got %0d want %0d", acc_port, exp_gnt); end
        if (n_acc > 0) begin
          total++;
          if (cyc - last_acc !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_acc); end
        end
        exp_q.push_back(req1_ready ? {1'b1, 1'b0, 8'h5A} : {1'b0, 1'b0, 8'h00});
        last_acc = cyc;
        n_acc++;
        exp_gnt = ~exp_gnt;
      end
      tick();
      if (n_acc == 4) begin
        req0_valid = 0; req1_valid = 0;
      end else if (acc_port == 0) begin
        req0_addr = req0_addr + 9'd1; req0_wdata = 8'($urandom_range(0, 255));
      end else if (acc_port == 1) begin
        req1_addr = req1_addr + 9'd1;
      end
      if (rsp_valid) begin
        n_rsp++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_rsp: unexpected response %h want none", {rsp_id, rsp_err, rsp_rdata});
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_id, rsp_err, rsp_rdata} !== exp) begin
            bad++; $display("FAIL b2b_rsp: got %h want %h", {rsp_id, rsp_err, rsp_rdata}, exp);
          end
        end
      end
      if (n_rsp == 4) break;
    end
    total++;
    if (n_rsp != 4) begin bad++; $display("FAIL b2b_count: got %0d responses want 4", n_rsp); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    PREADY1 = 1; PREADY2 = 0;
    tick();
    req1_valid = 1; req1_write = 0; req1_addr = 9'h120;
    settle();
    total++;
    if (req1_ready !== 1'b1) begin bad++; $display("FAIL rst_single_grant: got %b want 1", req1_ready); end
    tick();
    idle_inputs();
    tick();
    total++;
    if ({PSEL2, PENABLE} !== 2'b11) begin bad++; $display("FAIL rst_in_access: got %b want 11", {PSEL2, PENABLE}); end
    PRESET = 1;
    tick();
    PRESET = 0;
    total++;
    if ({PSEL1, PSEL2, PENABLE, rsp_valid} !== 4'b0000 || dbg_state !== IDLE) begin
      bad++; $display("FAIL rst_abort: got %b state %0d want 0000 state 0", {PSEL1, PSEL2, PENABLE, rsp_valid}, dbg_state);
    end
    req0_valid = 1; req0_write = 1; req0_addr = 9'h007; req0_wdata = 8'h11;
    req1_valid = 1; req1_write = 0; req1_addr = 9'h120;
    settle();
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL rst_regrant: ready={%b,%b} want {1,0}", req0_ready, req1_ready);
    end
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    tick();
    idle_inputs();
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (rsp_valid) begin
        seen = 1;
        total++;
        exp = exp_q.pop_front();
        if ({rsp_id, rsp_err, rsp_rdata} !== exp) begin
          bad++; $display("FAIL rst_rsp: got %h want %h", {rsp_id, rsp_err, rsp_rdata}, exp);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_rsp_timeout: got no response want 1"); end
  endtask

  task automatic test_unselected_ready();
    PREADY1 = 0; PREADY2 = 1; PRDATA1 = 8'h77; PRDATA2 = 8'hEE;
    tick();
    req0_valid = 1; req0_write = 0; req0_addr = 9'h010;
    settle();
    exp_q.push_back({1'b0, 1'b0, 8'h77});
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({PSEL1, PSEL2, PENABLE, rsp_valid} !== 4'b1010 || dbg_state !== ACCESS) begin
        bad++; $display("FAIL unsel_hold%0d: got %b state %0d want 1010 state 2", k, {PSEL1, PSEL2, PENABLE, rsp_valid}, dbg_state);
      end
    end
    PREADY1 = 1;
    tick();
    total++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL unsel_rsp: rsp_valid=%b queued=%0d want 1 and >0", rsp_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if ({rsp_id, rsp_err, rsp_rdata} !== exp) begin
        bad++; $display("FAIL unsel_rsp: got %h want %h", {rsp_id, rsp_err, rsp_rdata}, exp);
      end
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    PREADY1 = 0; PREADY2 = 1; PRDATA1 = 8'h77;
    tick();
    req0_valid = 1; req0_write = 0; req0_addr = 9'h033;
    settle();
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    tick();
    idle_inputs();
    for (int k = 0; k < TO_CYC; k++) begin
      tick();
      total++;
      if ({PSEL1, PENABLE, rsp_valid} !== 3'b110) begin
        bad++; $display("FAIL to_wait%0d: got %b want 110", k, {PSEL1, PENABLE, rsp_valid});
      end
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL to_rsp: rsp_valid=%b queued=%0d want 1 and >0", rsp_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if ({rsp_id, rsp_err, rsp_rdata} !== exp) begin
        bad++; $display("FAIL to_rsp: got %h want %h", {rsp_id, rsp_err, rsp_rdata}, exp);
      end
    end
    total++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin bad++; $display("FAIL to_release: got %b want 000", {PSEL1, PSEL2, PENABLE}); end
    PREADY1 = 1;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL to_idle: rsp_valid=%b state %0d want 0 state 0", rsp_valid, dbg_state);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_p0();
    test_read_wait_p1();
    test_back_to_back();
    test_reset_mid();
    test_unselected_ready();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
